// File: rtl/mult_preadd_acc_pipe.sv
// Four-stage pre-adder multiply-accumulate with valid/ready flow control.
// Output path rounds, shifts and saturates the accumulator to OUT_W bits.
module mult_preadd_acc_pipe #(
  parameter int unsigned A_W       = 12,
  parameter int unsigned B_W       = 12,
  parameter int unsigned D_W       = 12,
  parameter int unsigned OUT_W     = 24,
  parameter int unsigned SHIFT     = 0,
  parameter int unsigned ACC_GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a,
  input  logic signed [B_W-1:0]   in_b,
  input  logic signed [D_W-1:0]   in_d,
  input  logic [1:0]              in_mode,
  input  logic                    in_first,
  input  logic                    in_acc_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int unsigned PRE_W  = ((A_W > D_W) ? A_W : D_W) + 1;
  localparam int unsigned PROD_W = PRE_W + B_W;
  localparam int unsigned ACC_W  = PROD_W + ACC_GUARD;
  localparam int unsigned CMP_W  = ((ACC_W + 1) > OUT_W) ? (ACC_W + 1) : OUT_W;

  localparam logic signed [CMP_W-1:0] MAX_V =
    {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] MIN_V = ~MAX_V;

  logic                     w_advance;
  logic                     r1_valid, r2_valid, r3_valid;
  logic signed [A_W-1:0]    r1_a;
  logic signed [B_W-1:0]    r1_b, r2_b;
  logic signed [D_W-1:0]    r1_d;
  logic [1:0]               r1_mode;
  logic                     r1_first, r2_first, r3_first;
  logic                     r1_acc_en, r2_acc_en, r3_acc_en;
  logic signed [PRE_W-1:0]  w_ad, r2_ad;
  logic signed [PRE_W-1:0]  w_a_ext, w_d_ext;
  logic signed [PROD_W-1:0] w_m, r3_m;
  logic signed [ACC_W-1:0]  r_acc, w_m_ext, w_acc_next;
  logic signed [ACC_W:0]    w_acc_wide, w_r;
  logic signed [CMP_W-1:0]  w_rc, w_clip;
  logic                     w_sat;

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // Pre-adder operand select
  assign w_a_ext = PRE_W'(r1_a);
  assign w_d_ext = PRE_W'(r1_d);
  always_comb begin
    w_ad = w_a_ext;
    case (r1_mode)
      2'b00:   w_ad = w_a_ext;
      2'b01:   w_ad = w_d_ext + w_a_ext;
      2'b10:   w_ad = w_d_ext - w_a_ext;
      default: w_ad = w_d_ext;
    endcase
  end

  assign w_m        = PROD_W'(r2_ad) * PROD_W'(r2_b);
  assign w_m_ext    = ACC_W'(r3_m);
  assign w_acc_next = (r3_first || !r3_acc_en) ? w_m_ext : (r_acc + w_m_ext);
  assign w_acc_wide = (ACC_W+1)'(w_acc_next);

  // Round half up before the arithmetic shift; one extra bit absorbs the rounding carry
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
      logic signed [ACC_W:0] w_rnd;
      assign w_rnd = w_acc_wide + HALF;
      assign w_r   = w_rnd >>> SHIFT;
    end else begin : g_noround
      assign w_r = w_acc_wide;
    end
  endgenerate

  assign w_rc   = CMP_W'(w_r);
  assign w_sat  = (w_rc > MAX_V) || (w_rc < MIN_V);
  assign w_clip = !w_sat ? w_rc : (w_rc[CMP_W-1] ? MIN_V : MAX_V);

  // Control path: valid bits, accumulator and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      r3_valid  <= 1'b0;
      out_valid <= 1'b0;
      r_acc     <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (w_advance) begin
      r1_valid  <= in_valid;
      r2_valid  <= r1_valid;
      r3_valid  <= r2_valid;
      out_valid <= r3_valid;
      if (r3_valid) begin
        r_acc    <= w_acc_next;
        out_data <= OUT_W'(w_clip);
        out_sat  <= w_sat;
      end
    end
  end

  // Datapath stage registers load only with a valid beat
  always_ff @(posedge clk) begin
    if (w_advance) begin
      if (in_valid) begin
        r1_a      <= in_a;
        r1_b      <= in_b;
        r1_d      <= in_d;
        r1_mode   <= in_mode;
        r1_first  <= in_first;
        r1_acc_en <= in_acc_en;
      end
      if (r1_valid) begin
        r2_ad     <= w_ad;
        r2_b      <= r1_b;
        r2_first  <= r1_first;
        r2_acc_en <= r1_acc_en;
      end
      if (r2_valid) begin
        r3_m      <= w_m;
        r3_first  <= r2_first;
        r3_acc_en <= r2_acc_en;
      end
    end
  end

endmodule
